// File: rtl/shift_reg_univ_pkg.sv
// Shared encodings for the universal shift register: operation modes and FSM states.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_LOAD   = 3'b001;
  localparam logic [2:0] MODE_SHL    = 3'b010;
  localparam logic [2:0] MODE_SHR    = 3'b011;
  localparam logic [2:0] MODE_ROL    = 3'b100;
  localparam logic [2:0] MODE_ROR    = 3'b101;
  localparam logic [2:0] MODE_ASR    = 3'b110;
  localparam logic [2:0] MODE_SERIAL = 3'b111;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SERIAL = 1'b1
  } state_t;

endpackage

// File: rtl/shift_reg_univ.sv
// Parametrised universal register: parallel load, shift/rotate modes and an
// autonomous WIDTH-bit serialiser/deserialiser sequence with busy/done status.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_ser;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_mode_data;
  logic             w_mode_ser;
  logic [WIDTH-1:0] w_seq_data;
  logic             w_seq_ser;

  // Next-value candidates for idle mode operations and for one sequence shift.
  always_comb begin
    w_mode_data = r_data;
    w_mode_ser  = r_ser;
    case (mode)
      MODE_LOAD: w_mode_data = data_in;
      MODE_SHL: begin
        w_mode_data = {r_data[WIDTH-2:0], ser_in};
        w_mode_ser  = r_data[WIDTH-1];
      end
      MODE_SHR: begin
        w_mode_data = {ser_in, r_data[WIDTH-1:1]};
        w_mode_ser  = r_data[0];
      end
      MODE_ROL: begin
        w_mode_data = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        w_mode_ser  = r_data[WIDTH-1];
      end
      MODE_ROR: begin
        w_mode_data = {r_data[0], r_data[WIDTH-1:1]};
        w_mode_ser  = r_data[0];
      end
      MODE_ASR: begin
        w_mode_data = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
        w_mode_ser  = r_data[0];
      end
      default: ;
    endcase

    if (MSB_FIRST) begin
      w_seq_data = {r_data[WIDTH-2:0], ser_in};
      w_seq_ser  = r_data[WIDTH-1];
    end else begin
      w_seq_data = {ser_in, r_data[WIDTH-1:1]};
      w_seq_ser  = r_data[0];
    end
  end

  // A start request in SERIAL is dropped because mode is never decoded there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_ser   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_ser   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            if (mode == MODE_SERIAL) begin
              r_data  <= data_in;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_SERIAL;
            end else begin
              r_data <= w_mode_data;
              r_ser  <= w_mode_ser;
            end
          end
        end
        ST_SERIAL: begin
          if (en) begin
            r_data <= w_seq_data;
            r_ser  <= w_seq_ser;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out = r_data;
  assign ser_out  = r_ser;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: vector table for mode operations plus
// hand-written serial, stall, blocked-start and abort sequences on two directions.
module tb_shift_reg_univ;
  import shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic       clr;
  logic       en;
  logic [2:0] mode;
  logic       serIn;
  logic [7:0] dataIn;
  logic [7:0] dataOut, dataOutL;
  logic       serOut, serOutL;
  logic       busy, busyL;
  logic       done, doneL;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [2:0] mode;
    logic       en;
    logic       serIn;
    logic [7:0] dataIn;
    logic [7:0] expData;
    logic       expSer;
  } vec_t;

  vec_t vecs[16];

  shift_reg_univ #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rstN), .clr(clr), .en(en), .mode(mode), .ser_in(serIn),
    .data_in(dataIn), .data_out(dataOut), .ser_out(serOut), .busy(busy), .done(done)
  );

  shift_reg_univ #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst_n(rstN), .clr(clr), .en(en), .mode(mode), .ser_in(serIn),
    .data_in(dataIn), .data_out(dataOutL), .ser_out(serOutL), .busy(busyL), .done(doneL)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] m, input logic e, input logic s, input logic [7:0] d);
    mode   = m;
    en     = e;
    serIn  = s;
    dataIn = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] selData(input bit useLsb);
    return useLsb ? dataOutL : dataOut;
  endfunction

  function automatic logic selSer(input bit useLsb);
    return useLsb ? serOutL : serOut;
  endfunction

  function automatic logic selBusy(input bit useLsb);
    return useLsb ? busyL : busy;
  endfunction

  function automatic logic selDone(input bit useLsb);
    return useLsb ? doneL : done;
  endfunction

  // stallAfter < 0 disables the stall; blockStart keeps requesting a start with 0xFF while busy.
  task automatic runSerial(input logic [7:0] startVal, input bit loopback, input bit useLsb,
                           input int stallAfter, input bit blockStart);
    logic [7:0] model;
    logic       expBit;
    logic       lastSer;
    int         shifts     = 0;
    int         edges      = 0;
    int         stalls     = 0;
    int         busyCycles = 0;
    bit         stalling;
    applyStimulus(MODE_SERIAL, 1'b1, 1'b0, startVal);
    model   = startVal;
    lastSer = selSer(useLsb);
    checkOutput("seqStartData", selData(useLsb), startVal);
    checkOutput("seqStartBusy", selBusy(useLsb), 1);
    if (selBusy(useLsb)) busyCycles++;
    mode   = blockStart ? MODE_SERIAL : MODE_HOLD;
    dataIn = blockStart ? 8'hFF : 8'h00;
    while (shifts < 8 && edges < 40) begin
      stalling = (stallAfter >= 0) && (shifts == stallAfter) && (stalls < 3);
      expBit   = useLsb ? model[0] : model[7];
      en       = !stalling;
      serIn    = loopback ? expBit : 1'b0;
      @(posedge clk);
      #1;
      edges++;
      if (stalling) begin
        stalls++;
        checkOutput("stallData", selData(useLsb), model);
        checkOutput("stallSer", selSer(useLsb), lastSer);
        checkOutput("stallBusy", selBusy(useLsb), 1);
      end else begin
        model   = useLsb ? {serIn, model[7:1]} : {model[6:0], serIn};
        lastSer = expBit;
        shifts++;
        checkOutput($sformatf("serBit%0d", shifts), selSer(useLsb), expBit);
        checkOutput($sformatf("doneAt%0d", shifts), selDone(useLsb), (shifts == 8) ? 1 : 0);
      end
      if (selBusy(useLsb)) busyCycles++;
    end
    checkOutput("seqShiftCount", shifts, 8);
    checkOutput("seqBusyCycles", busyCycles, (stallAfter >= 0) ? 11 : 8);
    checkOutput("seqFinalData", selData(useLsb), loopback ? startVal : 8'h00);
    applyStimulus(MODE_HOLD, 1'b1, 1'b0, 8'h00);
    checkOutput("doneCleared", selDone(useLsb), 0);
    checkOutput("holdAfterSeq", selData(useLsb), loopback ? startVal : 8'h00);
  endtask

  initial begin
    vecs[0]  = '{MODE_LOAD, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0};
    vecs[1]  = '{MODE_SHL,  1'b1, 1'b1, 8'h00, 8'h4B, 1'b1};
    vecs[2]  = '{MODE_SHR,  1'b1, 1'b0, 8'h00, 8'h25, 1'b1};
    vecs[3]  = '{MODE_LOAD, 1'b0, 1'b0, 8'h3C, 8'h25, 1'b1};
    vecs[4]  = '{MODE_HOLD, 1'b1, 1'b0, 8'h3C, 8'h25, 1'b1};
    vecs[5]  = '{MODE_LOAD, 1'b1, 1'b0, 8'h81, 8'h81, 1'b1};
    vecs[6]  = '{MODE_ROL,  1'b1, 1'b0, 8'h00, 8'h03, 1'b1};
    vecs[7]  = '{MODE_LOAD, 1'b1, 1'b0, 8'h81, 8'h81, 1'b1};
    vecs[8]  = '{MODE_ROR,  1'b1, 1'b0, 8'h00, 8'hC0, 1'b1};
    vecs[9]  = '{MODE_LOAD, 1'b1, 1'b0, 8'h90, 8'h90, 1'b1};
    vecs[10] = '{MODE_ASR,  1'b1, 1'b1, 8'h00, 8'hC8, 1'b0};
    vecs[11] = '{MODE_ROL,  1'b1, 1'b0, 8'h00, 8'h91, 1'b1};
    vecs[12] = '{MODE_ROR,  1'b1, 1'b0, 8'h00, 8'hC8, 1'b1};
    vecs[13] = '{MODE_SHL,  1'b1, 1'b0, 8'h00, 8'h90, 1'b1};
    vecs[14] = '{MODE_SHR,  1'b1, 1'b1, 8'h00, 8'hC8, 1'b0};
    vecs[15] = '{MODE_ASR,  1'b1, 1'b0, 8'h00, 8'hE4, 1'b0};

    rstN = 1'b0; clr = 1'b0; en = 1'b0; mode = MODE_HOLD; serIn = 1'b0; dataIn = 8'h00;
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(MODE_LOAD, 1'b1, 1'b0, 8'hA5);
    checkOutput("preResetLoad", dataOut, 8'hA5);

    // Asynchronous reset between edges must clear outputs without a clock.
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstData", dataOut, 8'h00);
    checkOutput("rstSer", serOut, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(MODE_LOAD, 1'b1, 1'b0, 8'h01);
    checkOutput("firstLoad", dataOut, 8'h01);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].en, vecs[i].serIn, vecs[i].dataIn);
      checkOutput($sformatf("vec%0dData", i), dataOut, vecs[i].expData);
      checkOutput($sformatf("vec%0dSer", i), serOut, vecs[i].expSer);
      checkOutput($sformatf("vec%0dBusy", i), busy, 0);
    end

    for (int v = 0; v < 256; v++) begin
      applyStimulus(MODE_LOAD, 1'b1, 1'b0, 8'(v));
      checkOutput($sformatf("sweep%0d", v), dataOut, v);
    end

    runSerial(8'hC3, 1'b0, 1'b0, -1, 1'b0);
    runSerial(8'hC3, 1'b1, 1'b0, -1, 1'b0);
    runSerial(8'hC3, 1'b0, 1'b1, -1, 1'b0);
    runSerial(8'h01, 1'b0, 1'b1, -1, 1'b0);
    runSerial(8'hC3, 1'b1, 1'b0, 4, 1'b0);
    runSerial(8'hC3, 1'b1, 1'b0, -1, 1'b1);

    // Restart on the edge right after done.
    applyStimulus(MODE_SERIAL, 1'b1, 1'b0, 8'h96);
    for (int s = 0; s < 8; s++) applyStimulus(MODE_HOLD, 1'b1, 1'b0, 8'h00);
    checkOutput("b2bDone", done, 1);
    applyStimulus(MODE_SERIAL, 1'b1, 1'b0, 8'h5A);
    checkOutput("b2bRestartBusy", busy, 1);
    checkOutput("b2bRestartData", dataOut, 8'h5A);
    checkOutput("b2bRestartDone", done, 0);
    for (int s = 0; s < 8; s++) applyStimulus(MODE_HOLD, 1'b1, 1'b0, 8'h00);
    checkOutput("b2bSecondDone", done, 1);

    // Synchronous clear after four shifts aborts without done.
    applyStimulus(MODE_SERIAL, 1'b1, 1'b0, 8'hC3);
    for (int s = 0; s < 4; s++) applyStimulus(MODE_HOLD, 1'b1, 1'b0, 8'h00);
    checkOutput("preClrData", dataOut, 8'h30);
    clr = 1'b1;
    applyStimulus(MODE_HOLD, 1'b0, 1'b1, 8'hFF);
    clr = 1'b0;
    checkOutput("clrData", dataOut, 8'h00);
    checkOutput("clrSer", serOut, 0);
    checkOutput("clrBusy", busy, 0);
    checkOutput("clrDone", done, 0);
    applyStimulus(MODE_HOLD, 1'b1, 1'b0, 8'h00);
    checkOutput("clrNoLateDone", done, 0);
    checkOutput("clrStaysIdle", busy, 0);

    // Asynchronous reset mid-sequence, then a fresh sequence completes.
    applyStimulus(MODE_SERIAL, 1'b1, 1'b0, 8'hC3);
    for (int s = 0; s < 3; s++) applyStimulus(MODE_HOLD, 1'b1, 1'b0, 8'h00);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstData", dataOut, 8'h00);
    checkOutput("midRstSer", serOut, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", done, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    runSerial(8'h5A, 1'b1, 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
